// File: rtl/mem_bus_arbiter_if.sv
// Request/response ports of the fetch and data masters, the shared memory bus,
// and the arbiter status/control lines, bundled for the two-master arbiter.
interface mem_bus_arbiter_if;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_we;
  logic        i_start;
  logic [31:0] i_q;
  logic        i_done;
  logic [31:0] d_addr;
  logic [31:0] d_data;
  logic        d_we;
  logic        d_start;
  logic [31:0] d_q;
  logic        d_done;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        mem_start;
  logic [31:0] mem_q;
  logic        mem_done;
  logic        owner;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;

  modport slave (
    input  i_addr, i_data, i_we, i_start,
    output i_q, i_done,
    input  d_addr, d_data, d_we, d_start,
    output d_q, d_done,
    output mem_addr, mem_data, mem_we, mem_start,
    input  mem_q, mem_done,
    output owner, busy, timeout_err,
    input  err_clr
  );

  modport master (
    output i_addr, i_data, i_we, i_start,
    input  i_q, i_done,
    output d_addr, d_data, d_we, d_start,
    input  d_q, d_done,
    input  mem_addr, mem_data, mem_we, mem_start,
    output mem_q, mem_done,
    input  owner, busy, timeout_err,
    output err_clr
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/data) arbiter for a single memory bus with a watchdog that
// aborts transactions the slave never completes.
module mem_bus_arbiter #(
  parameter bit          DATA_PRIORITY  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      r_state;
  logic        r_rr_data_first;
  logic [15:0] r_wdog;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data;
  logic        r_mem_we;
  logic        r_mem_start;
  logic        r_owner;
  logic        r_busy;
  logic        r_timeout_err;
  logic [31:0] r_i_q;
  logic [31:0] r_d_q;
  logic        r_i_done;
  logic        r_d_done;

  logic        w_any_start;
  logic        w_tie;
  logic        w_grant_data;
  logic        w_timeout;
  logic        w_finish;
  logic [31:0] w_resp_q;

  // Winner selection, watchdog expiry and the value returned to the owner
  always_comb begin
    w_any_start = bus.i_start | bus.d_start;
    w_tie       = bus.i_start & bus.d_start;
    if (w_tie) begin
      w_grant_data = DATA_PRIORITY | r_rr_data_first;
    end else begin
      w_grant_data = bus.d_start;
    end
    w_timeout = (r_state == ST_ISSUE) && !bus.mem_done && (r_wdog == WDOG_LAST);
    w_finish  = (r_state == ST_ISSUE) && (bus.mem_done || w_timeout);
    if (bus.mem_done && !r_mem_we) begin
      w_resp_q = bus.mem_q;
    end else begin
      w_resp_q = 32'h0000_0000;
    end
  end

  // Arbitration FSM with all bus, response and status outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_rr_data_first <= 1'b1;
      r_wdog          <= 16'd0;
      r_mem_addr      <= 32'h0000_0000;
      r_mem_data      <= 32'h0000_0000;
      r_mem_we        <= 1'b0;
      r_mem_start     <= 1'b0;
      r_owner         <= 1'b0;
      r_busy          <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_i_q           <= 32'h0000_0000;
      r_d_q           <= 32'h0000_0000;
      r_i_done        <= 1'b0;
      r_d_done        <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      // A new abort outranks a simultaneous clear
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_timeout_err <= 1'b0;
      end else begin
        r_timeout_err <= r_timeout_err;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any_start) begin
            r_owner <= w_grant_data;
            if (w_grant_data) begin
              r_mem_addr <= bus.d_addr;
              r_mem_data <= bus.d_data;
              r_mem_we   <= bus.d_we;
            end else begin
              r_mem_addr <= bus.i_addr;
              r_mem_data <= bus.i_data;
              r_mem_we   <= bus.i_we;
            end
            if (w_tie && !DATA_PRIORITY) begin
              r_rr_data_first <= ~w_grant_data;
            end else begin
              r_rr_data_first <= r_rr_data_first;
            end
            r_wdog      <= 16'd0;
            r_mem_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (w_finish) begin
            if (r_owner) begin
              r_d_q    <= w_resp_q;
              r_d_done <= 1'b1;
            end else begin
              r_i_q    <= w_resp_q;
              r_i_done <= 1'b1;
            end
            r_mem_start <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_wdog  <= r_wdog + 16'd1;
            r_state <= ST_ISSUE;
          end
        end
        ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_start <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data    = r_mem_data;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_start   = r_mem_start;
  assign bus.owner       = r_owner;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
  assign bus.i_q         = r_i_q;
  assign bus.d_q         = r_d_q;
  assign bus.i_done      = r_i_done;
  assign bus.d_done      = r_d_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: a fixed-priority arbiter (dut_a) under directed and random
// traffic, and a round-robin arbiter (dut_b) under continuous ties.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_a ();
  mem_bus_arbiter_if bus_b ();

  mem_bus_arbiter #(.DATA_PRIORITY(1'b1), .TIMEOUT_CYCLES(32'd8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  mem_bus_arbiter #(.DATA_PRIORITY(1'b0), .TIMEOUT_CYCLES(32'd8)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // Slave for dut_a: answers after a_lat extra cycles, can be muted or forced to pulse
  int          a_lat = 0;
  int          a_cnt = 0;
  logic        a_mute = 1'b0;
  logic        a_inject = 1'b0;
  logic [31:0] a_q = 32'h0;

  always @(posedge clk) begin
    if (a_inject) begin
      bus_a.mem_done <= 1'b1;
      bus_a.mem_q    <= 32'hBAD0_BAD0;
      a_cnt          <= 0;
    end else if (bus_a.mem_start === 1'b1 && bus_a.mem_done !== 1'b1 && !a_mute) begin
      if (a_cnt >= a_lat) begin
        bus_a.mem_done <= 1'b1;
        bus_a.mem_q    <= a_q;
        a_cnt          <= 0;
      end else begin
        bus_a.mem_done <= 1'b0;
        bus_a.mem_q    <= 32'h0;
        a_cnt          <= a_cnt + 1;
      end
    end else begin
      bus_a.mem_done <= 1'b0;
      bus_a.mem_q    <= 32'h0;
      a_cnt          <= 0;
    end
  end

  // Slave for dut_b: one-cycle response, data derived from the address
  always @(posedge clk) begin
    if (bus_b.mem_start === 1'b1 && bus_b.mem_done !== 1'b1) begin
      bus_b.mem_done <= 1'b1;
      bus_b.mem_q    <= bus_b.mem_addr ^ 32'hFFFF_0000;
    end else begin
      bus_b.mem_done <= 1'b0;
      bus_b.mem_q    <= 32'h0;
    end
  end

  // Reference model state: outstanding request per master and the q each should hold
  logic [31:0] req_addr [2];
  logic [31:0] req_data [2];
  logic        req_we   [2];
  logic [31:0] mq       [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {25'd0, bus_a.mem_start, bus_a.mem_we, bus_a.i_done, bus_a.d_done,
                          bus_a.busy, bus_a.timeout_err, bus_a.owner}, 32'd0);
    check({tag, "_addr"}, bus_a.mem_addr, 32'd0);
    check({tag, "_data"}, bus_a.mem_data, 32'd0);
    check({tag, "_iq"}, bus_a.i_q, 32'd0);
    check({tag, "_dq"}, bus_a.d_q, 32'd0);
  endtask

  task automatic drive_req(input logic who, input logic [31:0] addr, input logic [31:0] data,
                           input logic we);
    req_addr[who] = addr;
    req_data[who] = data;
    req_we[who]   = we;
    if (who) begin
      bus_a.d_addr = addr; bus_a.d_data = data; bus_a.d_we = we; bus_a.d_start = 1'b1;
    end else begin
      bus_a.i_addr = addr; bus_a.i_data = data; bus_a.i_we = we; bus_a.i_start = 1'b1;
    end
  endtask

  // Expect the next grant to go to `who`, complete (or time out), and update q
  task automatic do_txn(input logic who, input logic [31:0] qv, input int lat,
                        input logic exp_to, input string tag);
    int   n;
    int   issue_cyc;
    logic prev_done;
    a_q = qv;
    a_lat = lat;
    n = 0;
    while (bus_a.mem_start !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    check({tag, "_grant_seen"}, 32'(n < 40), 32'd1);
    check({tag, "_owner"}, {31'd0, bus_a.owner}, {31'd0, who});
    check({tag, "_mem_addr"}, bus_a.mem_addr, req_addr[who]);
    check({tag, "_mem_data"}, bus_a.mem_data, req_data[who]);
    check({tag, "_mem_we"}, {31'd0, bus_a.mem_we}, {31'd0, req_we[who]});
    issue_cyc = 0;
    prev_done = 1'b0;
    n = 0;
    while (bus_a.i_done !== 1'b1 && bus_a.d_done !== 1'b1 && n < 60) begin
      if (bus_a.mem_start === 1'b1) issue_cyc++;
      prev_done = bus_a.mem_done;
      @(negedge clk); n++;
    end
    check({tag, "_done_seen"}, 32'(n < 60), 32'd1);
    check({tag, "_issue_cycles"}, issue_cyc, exp_to ? 32'd8 : 32'(lat + 2));
    check({tag, "_done_after_mem_done"}, {31'd0, prev_done}, {31'd0, ~exp_to});
    check({tag, "_done_route"}, {30'd0, bus_a.d_done, bus_a.i_done}, who ? 32'd2 : 32'd1);
    mq[who] = (exp_to || req_we[who]) ? 32'h0 : qv;
    check({tag, "_i_q"}, bus_a.i_q, mq[0]);
    check({tag, "_d_q"}, bus_a.d_q, mq[1]);
    check({tag, "_timeout_err"}, {31'd0, bus_a.timeout_err}, {31'd0, exp_to});
    if (who) bus_a.d_start = 1'b0;
    else bus_a.i_start = 1'b0;
  endtask

  initial begin
    logic rr_ptr;
    int   got;
    int   n;
    logic saw;

    reset = 1'b0;
    bus_a.i_addr = 32'h0; bus_a.i_data = 32'h0; bus_a.i_we = 1'b0; bus_a.i_start = 1'b0;
    bus_a.d_addr = 32'h0; bus_a.d_data = 32'h0; bus_a.d_we = 1'b0; bus_a.d_start = 1'b0;
    bus_a.err_clr = 1'b0;
    bus_b.i_addr = 32'h0; bus_b.i_data = 32'h0; bus_b.i_we = 1'b0; bus_b.i_start = 1'b0;
    bus_b.d_addr = 32'h0; bus_b.d_data = 32'h0; bus_b.d_we = 1'b0; bus_b.d_start = 1'b0;
    bus_b.err_clr = 1'b0;
    mq[0] = 32'h0; mq[1] = 32'h0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single fetch: one-cycle grant latency, slave answers 3 cycles after mem_start
    drive_req(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check("fetch_start_before_grant", {31'd0, bus_a.mem_start}, 32'd0);
    @(negedge clk);
    check("fetch_start_t1", {31'd0, bus_a.mem_start}, 32'd1);
    do_txn(1'b0, 32'hDEAD_BEEF, 2, 1'b0, "fetch");

    // Tie under fixed priority: data store first, then instruction fetch
    @(negedge clk);
    drive_req(1'b1, 32'h0000_0008, 32'h0000_0055, 1'b1);
    drive_req(1'b0, 32'h0000_0004, 32'h0, 1'b0);
    do_txn(1'b1, 32'h1234_5678, 1, 1'b0, "tie_d");
    do_txn(1'b0, 32'hCAFE_F00D, 0, 1'b0, "tie_i");

    // Abandoned fetch: start drops in ISSUE, bus cycle still finishes, data goes next
    @(negedge clk);
    drive_req(1'b0, 32'h0000_0020, 32'h0, 1'b0);
    @(negedge clk);
    bus_a.i_start = 1'b0;
    drive_req(1'b1, 32'h0000_0024, 32'h0, 1'b0);
    do_txn(1'b0, 32'hA5A5_0001, 3, 1'b0, "abandon_i");
    do_txn(1'b1, 32'hA5A5_0002, 1, 1'b0, "abandon_d");

    // Watchdog abort, sticky error until cleared, then normal traffic again
    @(negedge clk);
    a_mute = 1'b1;
    drive_req(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    do_txn(1'b0, 32'h7777_7777, 0, 1'b1, "timeout");
    a_mute = 1'b0;
    repeat (2) @(negedge clk);
    check("timeout_err_sticky", {31'd0, bus_a.timeout_err}, 32'd1);
    bus_a.err_clr = 1'b1;
    @(negedge clk);
    bus_a.err_clr = 1'b0;
    check("timeout_err_cleared", {31'd0, bus_a.timeout_err}, 32'd0);
    drive_req(1'b1, 32'h0000_0044, 32'h0, 1'b0);
    do_txn(1'b1, 32'h0BAD_F00D, 1, 1'b0, "after_timeout");

    // Random traffic: data always precedes a simultaneous fetch
    for (int r = 0; r < 16; r++) begin
      logic [1:0] sel;
      @(negedge clk);
      sel = 2'($urandom_range(1, 3));
      if (sel[1]) drive_req(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (sel[0]) drive_req(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (sel[1]) do_txn(1'b1, $urandom, $urandom_range(0, 3), 1'b0, "rnd_d");
      if (sel[0]) do_txn(1'b0, $urandom, $urandom_range(0, 3), 1'b0, "rnd_i");
    end

    // Round-robin: both masters hold start, owners must alternate starting with data
    @(negedge clk);
    bus_b.i_addr = 32'h0000_0100; bus_b.d_addr = 32'h0000_0200;
    bus_b.i_start = 1'b1; bus_b.d_start = 1'b1;
    rr_ptr = 1'b1;
    got = 0;
    n = 0;
    while (got < 6 && n < 200) begin
      @(negedge clk); n++;
      if (bus_b.i_done === 1'b1 || bus_b.d_done === 1'b1) begin
        check("rr_owner", {31'd0, bus_b.owner}, {31'd0, rr_ptr});
        check("rr_done_route", {30'd0, bus_b.d_done, bus_b.i_done}, rr_ptr ? 32'd2 : 32'd1);
        check("rr_q", rr_ptr ? bus_b.d_q : bus_b.i_q,
              (rr_ptr ? 32'h0000_0200 : 32'h0000_0100) ^ 32'hFFFF_0000);
        rr_ptr = ~rr_ptr;
        got++;
      end
    end
    bus_b.i_start = 1'b0; bus_b.d_start = 1'b0;
    check("rr_count", got, 32'd6);

    // Reset in the middle of ISSUE, then a stale mem_done must be ignored
    @(negedge clk);
    a_mute = 1'b1;
    drive_req(1'b0, 32'h0000_0080, 32'h0000_0011, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_reset_issue", {31'd0, bus_a.mem_start}, 32'd1);
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    bus_a.i_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    a_inject = 1'b1;
    @(negedge clk);
    a_inject = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      saw = saw | bus_a.i_done | bus_a.d_done | bus_a.mem_start;
      @(negedge clk);
    end
    check("stale_mem_done_ignored", {31'd0, saw}, 32'd0);
    a_mute = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
